// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: shares one test_ddr-style memory port between the
// instruction-fetch requester and the load/store requester. One transaction
// is in flight at a time. The winner's request is captured into the mem_*
// registers, held until mem_resp_v_i, and the response is returned to the
// winner as a one-cycle pulse.
//
// Handshake: a requester raises its valid and holds it until its resp_v
// pulse. Its fields are sampled only in the IDLE cycle in which it wins.
// mem_*_v_o stays high with stable fields until mem_resp_v_i is seen.
// mem_resp_v_i while IDLE is ignored.
//
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = BUSY_I, 2 = BUSY_D.
module rvga_mem_arbiter #(
  parameter int word_width_p    = 32,
  parameter int wmask_width_p   = 4,
  parameter int priority_mode_p = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_r_v_i,
  input  logic [word_width_p-1:0]  i_addr_i,
  output logic [word_width_p-1:0]  i_data_o,
  output logic                     i_resp_v_o,
  input  logic                     d_r_v_i,
  input  logic                     d_w_v_i,
  input  logic [word_width_p-1:0]  d_addr_i,
  input  logic [word_width_p-1:0]  d_data_i,
  input  logic [wmask_width_p-1:0] d_wmask_i,
  output logic [word_width_p-1:0]  d_data_o,
  output logic                     d_resp_v_o,
  output logic                     mem_r_v_o,
  output logic                     mem_w_v_o,
  output logic [word_width_p-1:0]  mem_addr_o,
  output logic [word_width_p-1:0]  mem_data_o,
  output logic [wmask_width_p-1:0] mem_wmask_o,
  input  logic [word_width_p-1:0]  mem_data_i,
  input  logic                     mem_resp_v_i,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     last_grant_q;  // 1 = data was served last
  logic [word_width_p-1:0]  i_data_q;
  logic                     i_resp_v_q;
  logic [word_width_p-1:0]  d_data_q;
  logic                     d_resp_v_q;
  logic                     mem_r_v_q;
  logic                     mem_w_v_q;
  logic [word_width_p-1:0]  mem_addr_q;
  logic [word_width_p-1:0]  mem_data_q;
  logic [wmask_width_p-1:0] mem_wmask_q;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // Pick the winner among the requests visible this cycle.
  always_comb begin
    d_req   = d_r_v_i | d_w_v_i;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (priority_mode_p == 1) begin
      grant_d = d_req;
      grant_i = i_r_v_i & ~d_req;
    end else if (i_r_v_i && d_req) begin
      // Tie: serve whoever was not served last.
      grant_i = last_grant_q;
      grant_d = ~last_grant_q;
    end else begin
      grant_i = i_r_v_i;
      grant_d = d_req;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      i_data_q     <= '0;
      i_resp_v_q   <= 1'b0;
      d_data_q     <= '0;
      d_resp_v_q   <= 1'b0;
      mem_r_v_q    <= 1'b0;
      mem_w_v_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wmask_q  <= '0;
    end else begin
      i_resp_v_q <= 1'b0;
      d_resp_v_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            mem_r_v_q   <= 1'b1;
            mem_w_v_q   <= 1'b0;
            mem_addr_q  <= i_addr_i;
            mem_data_q  <= '0;
            mem_wmask_q <= '0;
            state_q     <= BUSY_I;
          end else if (grant_d) begin
            // Read and write together is treated as a write.
            mem_r_v_q   <= ~d_w_v_i;
            mem_w_v_q   <= d_w_v_i;
            mem_addr_q  <= d_addr_i;
            mem_data_q  <= d_w_v_i ? d_data_i : '0;
            mem_wmask_q <= d_w_v_i ? d_wmask_i : '0;
            state_q     <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (mem_resp_v_i) begin
            i_data_q     <= mem_data_i;
            i_resp_v_q   <= 1'b1;
            mem_r_v_q    <= 1'b0;
            mem_w_v_q    <= 1'b0;
            last_grant_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_resp_v_i) begin
            d_data_q     <= mem_data_i;
            d_resp_v_q   <= 1'b1;
            mem_r_v_q    <= 1'b0;
            mem_w_v_q    <= 1'b0;
            last_grant_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_data_o    = i_data_q;
  assign i_resp_v_o  = i_resp_v_q;
  assign d_data_o    = d_data_q;
  assign d_resp_v_o  = d_resp_v_q;
  assign mem_r_v_o   = mem_r_v_q;
  assign mem_w_v_o   = mem_w_v_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_wmask_o = mem_wmask_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Bench for rvga_mem_arbiter: a round-robin instance checked every cycle
// against a transaction-level model, plus a fixed-priority instance checked
// with literal expectations.
module tb_rvga_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- DUT0 (round-robin) ----------------
  logic        i_r_v_i = 0, d_r_v_i = 0, d_w_v_i = 0;
  logic [31:0] i_addr_i = 0, d_addr_i = 0, d_data_i = 0;
  logic [3:0]  d_wmask_i = 0;
  logic [31:0] i_data_o, d_data_o, mem_addr_o, mem_data_o;
  logic        i_resp_v_o, d_resp_v_o, mem_r_v_o, mem_w_v_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_data_i = 0;
  logic        mem_resp_v_i = 0;
  logic [1:0]  dbg_state_o;

  rvga_mem_arbiter #(.word_width_p(32), .wmask_width_p(4), .priority_mode_p(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_r_v_i(i_r_v_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o), .i_resp_v_o(i_resp_v_o),
    .d_r_v_i(d_r_v_i), .d_w_v_i(d_w_v_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_wmask_i(d_wmask_i), .d_data_o(d_data_o), .d_resp_v_o(d_resp_v_o),
    .mem_r_v_o(mem_r_v_o), .mem_w_v_o(mem_w_v_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_wmask_o(mem_wmask_o), .mem_data_i(mem_data_i),
    .mem_resp_v_i(mem_resp_v_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- DUT1 (data-priority) ----------------
  logic        p1_i_r = 0, p1_d_r = 0;
  logic [31:0] p1_i_addr = 0, p1_d_addr = 0;
  logic [31:0] p1_i_data, p1_d_data, p1_mem_addr, p1_mem_data;
  logic        p1_i_resp, p1_d_resp, p1_mem_r, p1_mem_w;
  logic [3:0]  p1_mem_wmask;
  logic [31:0] p1_mem_rdata = 0;
  logic        p1_mem_resp = 0;
  logic [1:0]  p1_state;

  rvga_mem_arbiter #(.word_width_p(32), .wmask_width_p(4), .priority_mode_p(1)) dut_p1 (
    .clk_i(clk), .rst_i(rst),
    .i_r_v_i(p1_i_r), .i_addr_i(p1_i_addr), .i_data_o(p1_i_data), .i_resp_v_o(p1_i_resp),
    .d_r_v_i(p1_d_r), .d_w_v_i(1'b0), .d_addr_i(p1_d_addr), .d_data_i(32'h0),
    .d_wmask_i(4'h0), .d_data_o(p1_d_data), .d_resp_v_o(p1_d_resp),
    .mem_r_v_o(p1_mem_r), .mem_w_v_o(p1_mem_w), .mem_addr_o(p1_mem_addr),
    .mem_data_o(p1_mem_data), .mem_wmask_o(p1_mem_wmask), .mem_data_i(p1_mem_rdata),
    .mem_resp_v_i(p1_mem_resp), .dbg_state_o(p1_state)
  );

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory behind DUT0 ----------------
  logic [31:0] mem [logic [31:0]];
  int mem_lat  = 1;
  int wait_cnt = 0;
  int spur_req = 0;
  int spur_done = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory responder: answers mem_lat cycles after a request is seen.
  always @(negedge clk) begin
    logic [31:0] w;
    mem_resp_v_i = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (spur_req != spur_done) begin
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'hBAD0_BAD0;
      spur_done    = spur_req;
    end else if (mem_r_v_o || mem_w_v_o) begin
      if (wait_cnt >= mem_lat - 1) begin
        wait_cnt     = 0;
        mem_resp_v_i = 1'b1;
        w            = rd(mem_addr_o);
        mem_data_i   = w;
        if (mem_w_v_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask_o[b]) w[b*8 +: 8] = mem_data_o[b*8 +: 8];
          mem[mem_addr_o] = w;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Memory behind DUT1: one-cycle latency, returns address + 1.
  always @(negedge clk) begin
    p1_mem_resp = (p1_mem_r || p1_mem_w) && !p1_mem_resp && !rst;
    p1_mem_rdata = p1_mem_addr + 32'd1;
  end

  // ---------------- transaction model of DUT0 ----------------
  // Tracks: is a transfer outstanding, who owns it, what was captured,
  // who was served last, and the delivered responses.
  logic        m_busy, m_owner_d, m_last_d, m_r, m_w, m_iresp, m_dresp;
  logic [31:0] m_addr, m_wdata, m_idata, m_ddata;
  logic [3:0]  m_wmask;

  // 0 = nobody, 1 = instruction, 2 = data
  function automatic int winner(input logic want_i, input logic want_d, input logic last_d);
    if (want_i && want_d) return last_d ? 1 : 2;
    if (want_i) return 1;
    if (want_d) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_owner_d <= 0; m_last_d <= 1; m_r <= 0; m_w <= 0;
      m_iresp <= 0; m_dresp <= 0; m_addr <= 0; m_wdata <= 0; m_wmask <= 0;
      m_idata <= 0; m_ddata <= 0;
    end else begin
      m_iresp <= 0;
      m_dresp <= 0;
      if (!m_busy) begin
        case (winner(i_r_v_i, d_r_v_i | d_w_v_i, m_last_d))
          1: begin
            m_busy <= 1; m_owner_d <= 0; m_r <= 1; m_w <= 0;
            m_addr <= i_addr_i; m_wdata <= 0; m_wmask <= 0;
          end
          2: begin
            m_busy <= 1; m_owner_d <= 1; m_r <= !d_w_v_i; m_w <= d_w_v_i;
            m_addr <= d_addr_i;
            m_wdata <= d_w_v_i ? d_data_i : 32'h0;
            m_wmask <= d_w_v_i ? d_wmask_i : 4'h0;
          end
          default: ;
        endcase
      end else if (mem_resp_v_i) begin
        m_busy <= 0; m_r <= 0; m_w <= 0; m_last_d <= m_owner_d;
        if (m_owner_d) begin m_dresp <= 1; m_ddata <= mem_data_i; end
        else begin m_iresp <= 1; m_idata <= mem_data_i; end
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] obs_q[$];  // addresses of DUT0 grants in order
  logic [31:0] exp_q[$];  // expected grant addresses
  int i_resp_cnt = 0, d_resp_cnt = 0, p1_i_grants = 0, p1_d_grants = 0;
  logic prev_v = 0, p1_prev_v = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("mem_r_v", 32'(mem_r_v_o), 32'(m_r));
      chk("mem_w_v", 32'(mem_w_v_o), 32'(m_w));
      chk("i_resp_v", 32'(i_resp_v_o), 32'(m_iresp));
      chk("d_resp_v", 32'(d_resp_v_o), 32'(m_dresp));
      chk("i_data", i_data_o, m_idata);
      chk("d_data", d_data_o, m_ddata);
      chk("busy", 32'(dbg_state_o != 2'd0), 32'(m_busy));
      if (m_r || m_w) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_data", mem_data_o, m_wdata);
        chk("mem_wmask", 32'(mem_wmask_o), 32'(m_wmask));
      end
      if (i_resp_v_o) i_resp_cnt++;
      if (d_resp_v_o) d_resp_cnt++;
      if ((mem_r_v_o || mem_w_v_o) && !prev_v) obs_q.push_back(mem_addr_o);
      prev_v = mem_r_v_o || mem_w_v_o;
      if (p1_mem_r && !p1_prev_v) begin
        if (p1_mem_addr == 32'h300) p1_i_grants++;
        else p1_d_grants++;
      end
      p1_prev_v = p1_mem_r;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input int sel, input string name);
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      case (sel)
        0: seen = i_resp_v_o;
        1: seen = d_resp_v_o;
        2: seen = i_resp_v_o | d_resp_v_o;
        3: seen = p1_i_resp;
        default: seen = p1_d_resp;
      endcase
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_grants(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < obs_q.size()) chk({name, "_order"}, obs_q[k], exp_q[k]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int ic, dc;
    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h200] = 32'h1234_5678;
    mem[32'h40]  = 32'h4040_4040;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
    chk("rst_mem_w_v", 32'(mem_w_v_o), 32'd0);
    chk("rst_i_resp", 32'(i_resp_v_o), 32'd0);
    chk("rst_d_resp", 32'(d_resp_v_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Instruction only, 2-cycle memory
    mem_lat = 2;
    ic = i_resp_cnt; dc = d_resp_cnt;
    @(negedge clk);
    i_r_v_i = 1; i_addr_i = 32'h100;
    wait_pulse(0, "t1_i_resp");
    chk("t1_i_data", i_data_o, 32'hDEAD_BEEF);
    i_r_v_i = 0;
    repeat (3) @(negedge clk);
    chk("t1_i_count", i_resp_cnt - ic, 1);
    chk("t1_d_count", d_resp_cnt - dc, 0);
    obs_q.delete();

    // Both requesting from reset: instr, data, instr, data
    do_reset();
    mem_lat = 1;
    ic = i_resp_cnt; dc = d_resp_cnt;
    i_r_v_i = 1; i_addr_i = 32'h0;
    d_w_v_i = 1; d_addr_i = 32'h2000; d_data_i = 32'h55AA; d_wmask_i = 4'h3;
    for (int k = 0; k < 4; k++) wait_pulse(2, "t2_resp");
    i_r_v_i = 0; d_w_v_i = 0;
    repeat (3) @(negedge clk);
    exp_q = '{32'h0, 32'h2000, 32'h0, 32'h2000};
    check_grants("t2_grant");
    chk("t2_i_count", i_resp_cnt - ic, 2);
    chk("t2_d_count", d_resp_cnt - dc, 2);
    chk("t2_mem_word", rd(32'h2000), 32'hA5A5_55AA);
    chk("t2_i_data", i_data_o, 32'hA5A5_0000);
    chk("t2_d_data", d_data_o, 32'hA5A5_55AA);

    // Address change while busy is ignored; new address served next
    mem_lat = 3;
    @(negedge clk);
    i_r_v_i = 1; i_addr_i = 32'h100;
    @(negedge clk);
    i_addr_i = 32'h200;
    wait_pulse(0, "t3_first");
    chk("t3_first_data", i_data_o, 32'hDEAD_BEEF);
    wait_pulse(0, "t3_second");
    chk("t3_second_data", i_data_o, 32'h1234_5678);
    i_r_v_i = 0;
    repeat (3) @(negedge clk);
    exp_q = '{32'h100, 32'h200};
    check_grants("t3_grant");

    // Spurious response in IDLE, then read+write treated as write
    mem_lat = 1;
    ic = i_resp_cnt; dc = d_resp_cnt;
    spur_req++;
    repeat (3) @(negedge clk);
    chk("t4_spur_i", i_resp_cnt - ic, 0);
    chk("t4_spur_d", d_resp_cnt - dc, 0);
    chk("t4_spur_state", 32'(dbg_state_o), 32'd0);
    d_r_v_i = 1; d_w_v_i = 1; d_addr_i = 32'h3000; d_data_i = 32'hCAFE_F00D; d_wmask_i = 4'hF;
    @(negedge clk);
    chk("t4_rw_w", 32'(mem_w_v_o), 32'd1);
    chk("t4_rw_r", 32'(mem_r_v_o), 32'd0);
    wait_pulse(1, "t4_d_resp");
    d_r_v_i = 0; d_w_v_i = 0;
    repeat (2) @(negedge clk);
    chk("t4_mem_word", rd(32'h3000), 32'hCAFE_F00D);

    // Reset while BUSY_D with response pending
    mem_lat = 5;
    d_r_v_i = 1; d_addr_i = 32'h2000;
    @(negedge clk);
    chk("t5_busy_r", 32'(mem_r_v_o), 32'd1);
    @(negedge clk);
    dc = d_resp_cnt;
    rst = 1'b1;
    #1;
    chk("t5_rst_r", 32'(mem_r_v_o), 32'd0);
    chk("t5_rst_w", 32'(mem_w_v_o), 32'd0);
    chk("t5_rst_state", 32'(dbg_state_o), 32'd0);
    d_r_v_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_no_d_resp", d_resp_cnt - dc, 0);
    mem_lat = 1;
    i_r_v_i = 1; i_addr_i = 32'h40;
    wait_pulse(0, "t5_i_resp");
    chk("t5_i_data", i_data_o, 32'h4040_4040);
    i_r_v_i = 0;
    repeat (3) @(negedge clk);

    // Fixed priority: data wins six times, then instr
    p1_i_r = 1; p1_i_addr = 32'h300;
    p1_d_r = 1; p1_d_addr = 32'h500;
    for (int k = 0; k < 6; k++) wait_pulse(4, "t6_d_resp");
    p1_d_r = 0;
    chk("t6_i_grants", p1_i_grants, 0);
    chk("t6_d_grants", p1_d_grants, 6);
    chk("t6_d_data", p1_d_data, 32'h501);
    wait_pulse(3, "t6_i_resp");
    chk("t6_i_data", p1_i_data, 32'h301);
    p1_i_r = 0;
    repeat (3) @(negedge clk);
    chk("t6_d_grants_end", p1_d_grants, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rvga_mem_arbiter.md
Name: rvga_mem_arbiter

Overview:
- Shares one test_ddr-style memory port between the instruction-fetch requester and the load/store requester of rvga_top.
- Lets a single backing memory serve both imem and dmem traffic.
- Registered FSM: grants one requester, holds the downstream request stable until the memory responds, then returns the response to the granted requester.
- Sits between rvga_top and a single test_ddr instance in the unified-memory bench/top.

Parameters:
- word_width_p, 32, width of address and data words (rvga_word).
- wmask_width_p, 4, byte write-mask width (word_width_p/8).
- priority_mode_p, 0, 0 = round-robin between instr/data; 1 = fixed priority, data always wins.

Ports:
- clk_i  in  1  clock, single domain.
- rst_i  in  1  asynchronous, active-high reset.
- i_r_v_i  in  1  instruction read request valid.
- i_addr_i  in  word_width_p  instruction address.
- i_data_o  out  word_width_p  instruction read data.
- i_resp_v_o  out  1  one-cycle pulse: instruction response valid.
- d_r_v_i  in  1  data read request.
- d_w_v_i  in  1  data write request.
- d_addr_i  in  word_width_p  data address.
- d_data_i  in  word_width_p  write data.
- d_wmask_i  in  wmask_width_p  byte write mask.
- d_data_o  out  word_width_p  load data.
- d_resp_v_o  out  1  one-cycle pulse: data response valid (reads and writes).
- mem_r_v_o  out  1  downstream read request.
- mem_w_v_o  out  1  downstream write request.
- mem_addr_o  out  word_width_p  downstream address.
- mem_data_o  out  word_width_p  downstream write data.
- mem_wmask_o  out  wmask_width_p  downstream write mask.
- mem_data_i  in  word_width_p  downstream read data.
- mem_resp_v_i  in  1  downstream response valid.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high on rst_i.
- Reset values:
  - All outputs 0.
  - FSM = IDLE.
  - last_grant = DATA, so instr wins the first tie.
- FSM states:
  - IDLE: no transaction in flight. Sample requests; pick a winner; register addr/data/wmask/kind from the winner into the mem_* output registers; go to BUSY_I or BUSY_D. No request: stay in IDLE with mem_r_v_o = mem_w_v_o = 0.
  - BUSY_I / BUSY_D: mem_* outputs held constant every cycle. On mem_resp_v_i:
    - register mem_data_i into i_data_o or d_data_o (d_data_o is updated for writes too; its value is don't-care for a write);
    - pulse the matching *_resp_v_o for exactly 1 cycle;
    - clear mem_r_v_o/mem_w_v_o;
    - update last_grant;
    - return to IDLE.
- Latency:
  - Request visible at edge N gives mem_*_v_o high after edge N.
  - mem_resp_v_i at edge M gives resp_v_o/data high after edge M and low after M+1.
  - Mandatory one-cycle IDLE bubble between transactions; minimum 2 cycles per transaction plus memory latency.
- Arbitration:
  - priority_mode_p=0: when both request, grant the one not equal to last_grant; a single requester is granted regardless of last_grant.
  - priority_mode_p=1: data wins whenever it requests; instr is served only when data is idle.
- Data kind: d_w_v_i && d_r_v_i both high is treated as a write (mem_w_v_o=1, mem_r_v_o=0). A data request is d_r_v_i || d_w_v_i.
- Requester contract:
  - Requesters hold their request until their resp_v pulse.
  - Input changes after the grant are ignored because the request is captured.
  - A requester dropping its request mid-flight does not cancel: the transaction completes and resp_v still pulses.
- Non-winner: its inputs are not captured; it keeps requesting and is served in a later IDLE cycle.
- mem_resp_v_i in IDLE is ignored: no outputs change and no state change.
- mem_data_o and mem_wmask_o are 0 for reads.
- Reset mid-transaction: all outputs, including mem_*_v_o, go to 0 immediately (async). No response is delivered. The FSM restarts in IDLE after release.

Test Plan:
- Instr only, 2-cycle memory: i_r_v_i=1, i_addr_i=0x100, mem returns 0xDEADBEEF → mem_r_v_o high with mem_addr_o=0x100 until resp; i_resp_v_o single pulse with i_data_o=0xDEADBEEF; d_resp_v_o stays 0.
- Simultaneous requests, priority_mode_p=0, out of reset: instr 0x0 and data write 0x2000/0x55AA/wmask 0x3 held high → grant order instr, data, instr, data; mem_w_v_o=1 with mem_wmask_o=0x3 on the data slots; each requester gets one resp pulse per transaction.
- priority_mode_p=1, both held high for 6 transactions → all 6 granted to data; instr served only after d_r_v_i drops.
- Instr requester changes i_addr_i 0x100 → 0x200 while BUSY_I → mem_addr_o stays 0x100 until mem_resp_v_i; 0x200 is served next.
- Spurious mem_resp_v_i in IDLE → no resp pulses, FSM stays IDLE. d_r_v_i=d_w_v_i=1 → mem_w_v_o=1, mem_r_v_o=0.
- Assert rst_i in BUSY_D with resp pending → mem_*_v_o=0 same cycle, no d_resp_v_o; after release, a new instr request at 0x40 completes normally.
